gemm_tile_scheduler: RTL and testbench

Control sequencer that walks the (m, n, k) tile space of a GEMM C = A·B. It issues one tile command per accepted valid/ready handshake to the tile datapath: the A/B tile readers plus the tile MAC PE. After the last k-block of each output tile, it waits for the C write-back unit to report completion before moving on. Non-multiple-of-TileDim dimensions are handled through per-command edge extents, and zero-sized dimensions are rejected.

---
 rtl/gemm_pkg.sv | 38 +++
 rtl/gemm_tile_scheduler_tile_index_counter.sv | 64 ++++++
 rtl/gemm_tile_scheduler.sv | 146 ++++++++++++++
 tb/tb_gemm_tile_scheduler.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// Shared types and tile arithmetic for the GEMM tile scheduler and its index counter.
package gemm_pkg;
  localparam int DefDimWidth = 16;
  localparam int DefTileDim  = 4;
  localparam int DefExtWidth = $clog2(DefTileDim + 1);
  localparam int TileShift   = $clog2(DefTileDim);
  localparam int CntWidth    = DefDimWidth + 1;

  typedef logic [DefDimWidth-1:0] dim_t;
  typedef logic [CntWidth-1:0]    cnt_t;
  typedef logic [DefExtWidth-1:0] ext_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_WB, S_DONE} sched_state_t;

  typedef struct packed {
    dim_t m;
    dim_t n;
    dim_t k;
    logic first_k;
    logic last_k;
    ext_t rows;
    ext_t cols;
    ext_t depth;
  } tile_cmd_t;

  // The extra count bit keeps ceil(0xFFFF / TileDim) from wrapping to zero.
  function automatic cnt_t ceil_tiles(input dim_t dim);
    cnt_t wide;
    wide = {1'b0, dim} + cnt_t'(DefTileDim - 1);
    return wide >> TileShift;
  endfunction

  function automatic ext_t edge_ext(input dim_t dim, input dim_t idx);
    cnt_t rem;
    rem = {1'b0, dim} - ({1'b0, idx} << TileShift);
    return (rem >= cnt_t'(DefTileDim)) ? ext_t'(DefTileDim) : rem[DefExtWidth-1:0];
  endfunction
endpackage

// File: rtl/gemm_tile_scheduler_tile_index_counter.sv
// Nested wrapping tile index counter: k innermost, then n, then m.
module tile_index_counter
  import gemm_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic advance_i,
  input  cnt_t tilesK_i,
  input  cnt_t tilesN_i,
  input  cnt_t tilesM_i,
  output dim_t idxK_o,
  output dim_t idxN_o,
  output dim_t idxM_o,
  output logic lastK_o,
  output logic lastTile_o
);
  dim_t idxK_q, idxN_q, idxM_q;
  dim_t idxK_d, idxN_d, idxM_d;
  logic lastN, lastM;

  always_comb begin
    lastK_o    = cnt_t'(idxK_q) == tilesK_i - cnt_t'(1);
    lastN      = cnt_t'(idxN_q) == tilesN_i - cnt_t'(1);
    lastM      = cnt_t'(idxM_q) == tilesM_i - cnt_t'(1);
    lastTile_o = lastN && lastM;
    idxK_d = idxK_q;
    idxN_d = idxN_q;
    idxM_d = idxM_q;
    if (clear_i) begin
      idxK_d = '0;
      idxN_d = '0;
      idxM_d = '0;
    end else if (advance_i) begin
      if (!lastK_o) begin
        idxK_d = idxK_q + dim_t'(1);
      end else begin
        idxK_d = '0;
        if (!lastN) begin
          idxN_d = idxN_q + dim_t'(1);
        end else begin
          idxN_d = '0;
          if (!lastM) idxM_d = idxM_q + dim_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idxK_q <= '0;
      idxN_q <= '0;
      idxM_q <= '0;
    end else begin
      idxK_q <= idxK_d;
      idxN_q <= idxN_d;
      idxM_q <= idxM_d;
    end
  end

  assign idxK_o = idxK_q;
  assign idxN_o = idxN_q;
  assign idxM_o = idxM_q;
endmodule

// File: rtl/gemm_tile_scheduler.sv
// Walks the (m, n, k) tile space of a GEMM, issuing one tile command per handshake
// and waiting for C write-back after the last k-block of each output tile.
module gemm_tile_scheduler
  import gemm_pkg::*;
#(
  parameter int DimWidth = DefDimWidth,
  parameter int TileDim  = DefTileDim,
  parameter int ExtWidth = $clog2(TileDim + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [DimWidth-1:0] M_i,
  input  logic [DimWidth-1:0] K_i,
  input  logic [DimWidth-1:0] N_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                cfg_err_o,
  output logic                cmd_valid_o,
  input  logic                cmd_ready_i,
  output logic [DimWidth-1:0] cmd_tile_m_o,
  output logic [DimWidth-1:0] cmd_tile_n_o,
  output logic [DimWidth-1:0] cmd_tile_k_o,
  output logic                cmd_first_k_o,
  output logic                cmd_last_k_o,
  output logic [ExtWidth-1:0] cmd_rows_o,
  output logic [ExtWidth-1:0] cmd_cols_o,
  output logic [ExtWidth-1:0] cmd_depth_o,
  input  logic                wb_done_i
);
  sched_state_t state_q;
  dim_t         dimM_q, dimK_q, dimN_q;
  cnt_t         tilesM_q, tilesK_q, tilesN_q;
  logic         cmdValid_q, busy_q, done_q, cfgErr_q;
  dim_t         idxM, idxN, idxK;
  logic         lastK, lastTile, clearIdx, advanceIdx;
  tile_cmd_t    cmd;

  // wb_done_i only counts in S_WAIT_WB, so a pulse coinciding with the last_k handshake is dropped.
  assign clearIdx   = (state_q == S_IDLE) && start_i;
  assign advanceIdx = ((state_q == S_ISSUE) && cmd_ready_i && !lastK) ||
                      ((state_q == S_WAIT_WB) && wb_done_i);

  tile_index_counter u_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (clearIdx),
    .advance_i  (advanceIdx),
    .tilesK_i   (tilesK_q),
    .tilesN_i   (tilesN_q),
    .tilesM_i   (tilesM_q),
    .idxK_o     (idxK),
    .idxN_o     (idxN),
    .idxM_o     (idxM),
    .lastK_o    (lastK),
    .lastTile_o (lastTile)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      dimM_q     <= '0;
      dimK_q     <= '0;
      dimN_q     <= '0;
      tilesM_q   <= '0;
      tilesK_q   <= '0;
      tilesN_q   <= '0;
      cmdValid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfgErr_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            dimM_q   <= M_i;
            dimK_q   <= K_i;
            dimN_q   <= N_i;
            tilesM_q <= ceil_tiles(M_i);
            tilesK_q <= ceil_tiles(K_i);
            tilesN_q <= ceil_tiles(N_i);
            if (M_i == '0 || K_i == '0 || N_i == '0) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              cfgErr_q <= 1'b1;
            end else begin
              state_q    <= S_ISSUE;
              cmdValid_q <= 1'b1;
              busy_q     <= 1'b1;
              cfgErr_q   <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          if (cmd_ready_i && lastK) begin
            cmdValid_q <= 1'b0;
            state_q    <= S_WAIT_WB;
          end
        end
        S_WAIT_WB: begin
          if (wb_done_i) begin
            if (lastTile) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_ISSUE;
              cmdValid_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (!start_i) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd.m       = idxM;
    cmd.n       = idxN;
    cmd.k       = idxK;
    cmd.first_k = cmdValid_q && (idxK == '0);
    cmd.last_k  = cmdValid_q && lastK;
    cmd.rows    = edge_ext(dimM_q, idxM);
    cmd.cols    = edge_ext(dimN_q, idxN);
    cmd.depth   = edge_ext(dimK_q, idxK);
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign cfg_err_o     = cfgErr_q;
  assign cmd_valid_o   = cmdValid_q;
  assign cmd_tile_m_o  = cmd.m;
  assign cmd_tile_n_o  = cmd.n;
  assign cmd_tile_k_o  = cmd.k;
  assign cmd_first_k_o = cmd.first_k;
  assign cmd_last_k_o  = cmd.last_k;
  assign cmd_rows_o    = cmd.rows;
  assign cmd_cols_o    = cmd.cols;
  assign cmd_depth_o   = cmd.depth;
endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Randomized testbench for gemm_tile_scheduler against a loop-nest reference model.
module tb_gemm_tile_scheduler;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] M_i = '0, K_i = '0, N_i = '0;
  logic        busy_o, done_o, cfg_err_o, cmd_valid_o;
  logic        cmd_ready_i = 1'b0;
  logic [15:0] cmd_tile_m_o, cmd_tile_n_o, cmd_tile_k_o;
  logic        cmd_first_k_o, cmd_last_k_o;
  logic [2:0]  cmd_rows_o, cmd_cols_o, cmd_depth_o;
  logic        wb_done_i = 1'b0;

  typedef struct packed {
    logic [15:0] m;
    logic [15:0] n;
    logic [15:0] k;
    logic        firstK;
    logic        lastK;
    logic [2:0]  rows;
    logic [2:0]  cols;
    logic [2:0]  depth;
  } cmdRec_t;

  int checkCount = 0;
  int failCount  = 0;
  logic [62:0] allOut;

  assign allOut = {busy_o, done_o, cfg_err_o, cmd_valid_o, cmd_tile_m_o, cmd_tile_n_o,
                   cmd_tile_k_o, cmd_first_k_o, cmd_last_k_o, cmd_rows_o, cmd_cols_o, cmd_depth_o};

  always #5 clk_i = ~clk_i;

  gemm_tile_scheduler dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .M_i(M_i), .K_i(K_i), .N_i(N_i),
    .busy_o(busy_o), .done_o(done_o), .cfg_err_o(cfg_err_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_tile_m_o(cmd_tile_m_o), .cmd_tile_n_o(cmd_tile_n_o), .cmd_tile_k_o(cmd_tile_k_o),
    .cmd_first_k_o(cmd_first_k_o), .cmd_last_k_o(cmd_last_k_o),
    .cmd_rows_o(cmd_rows_o), .cmd_cols_o(cmd_cols_o), .cmd_depth_o(cmd_depth_o),
    .wb_done_i(wb_done_i)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int extentOf(input int dim, input int idx);
    int rem;
    rem = dim - 4 * idx;
    return (rem >= 4) ? 4 : rem;
  endfunction

  // One full run: drives start, a random ready, write-back pulses 3 cycles after each last_k,
  // and optionally spurious start toggles and wb_done pulses while commands are being issued.
  task automatic applyStimulus(input int mDim, input int kDim, input int nDim,
                               input int readyPct, input bit spurious);
    cmdRec_t expQ[$];
    cmdRec_t rec, obs, heldCmd;
    int mt, kt, nt, wbCd, wbSeen, cycles, lastWbCycle;
    bit held, finished, wb;
    mt = (mDim + 3) / 4;
    kt = (kDim + 3) / 4;
    nt = (nDim + 3) / 4;
    for (int m = 0; m < mt; m++)
      for (int n = 0; n < nt; n++)
        for (int k = 0; k < kt; k++) begin
          rec.m      = 16'(m);
          rec.n      = 16'(n);
          rec.k      = 16'(k);
          rec.firstK = (k == 0);
          rec.lastK  = (k == kt - 1);
          rec.rows   = 3'(extentOf(mDim, m));
          rec.cols   = 3'(extentOf(nDim, n));
          rec.depth  = 3'(extentOf(kDim, k));
          expQ.push_back(rec);
        end
    M_i = 16'(mDim);
    K_i = 16'(kDim);
    N_i = 16'(nDim);
    start_i = 1'b1;
    cmd_ready_i = 1'b0;
    wb_done_i = 1'b0;
    wbCd = 0; wbSeen = 0; cycles = 0; lastWbCycle = -100;
    held = 0; finished = 0;
    @(negedge clk_i);
    checkOutput("firstValid", {63'd0, cmd_valid_o}, 64'd1);
    checkOutput("cfgErrClear", {63'd0, cfg_err_o}, 64'd0);
    while (!finished && cycles < 4000) begin
      obs = {cmd_tile_m_o, cmd_tile_n_o, cmd_tile_k_o, cmd_first_k_o, cmd_last_k_o,
             cmd_rows_o, cmd_cols_o, cmd_depth_o};
      if (done_o) begin
        checkOutput("wbCount", 64'(wbSeen), 64'(mt * nt));
        checkOutput("cmdLeft", 64'(expQ.size()), 64'd0);
        checkOutput("doneLatency", 64'(cycles - lastWbCycle), 64'd1);
        checkOutput("busyAtDone", {63'd0, busy_o}, 64'd0);
        finished = 1;
      end else begin
        if (held) begin
          checkOutput("validHeld", {63'd0, cmd_valid_o}, 64'd1);
          checkOutput("stable", 64'(obs), 64'(heldCmd));
        end
        wb = (wbCd == 1);
        if (wb) begin
          wbSeen++;
          lastWbCycle = cycles;
        end
        if (wbCd > 0) wbCd--;
        if (spurious && cmd_valid_o && $urandom_range(0, 3) == 0) wb = 1'b1;
        start_i = (spurious && cmd_valid_o) ? 1'($urandom_range(0, 1)) : 1'b1;
        cmd_ready_i = ($urandom_range(0, 99) < readyPct);
        if (cmd_valid_o && cmd_ready_i) begin
          if (expQ.size() == 0) checkOutput("extraCmd", 64'd1, 64'd0);
          else checkOutput("cmd", 64'(obs), 64'(expQ.pop_front()));
          if (cmd_last_k_o) wbCd = 3;
          held = 0;
        end else begin
          held = cmd_valid_o;
          heldCmd = obs;
        end
        wb_done_i = wb;
        cycles++;
        @(negedge clk_i);
      end
    end
    if (!finished) checkOutput("timeout", 64'd0, 64'd1);
    start_i = 1'b0;
    cmd_ready_i = 1'b0;
    wb_done_i = 1'b0;
    @(negedge clk_i);
    checkOutput("doneDrop", {63'd0, done_o}, 64'd0);
    checkOutput("idleBusy", {63'd0, busy_o}, 64'd0);
  endtask

  task automatic applyZero(input int mDim, input int kDim, input int nDim);
    M_i = 16'(mDim);
    K_i = 16'(kDim);
    N_i = 16'(nDim);
    start_i = 1'b1;
    @(negedge clk_i);
    checkOutput("zeroValid", {63'd0, cmd_valid_o}, 64'd0);
    checkOutput("zeroDone", {63'd0, done_o}, 64'd1);
    checkOutput("zeroErr", {63'd0, cfg_err_o}, 64'd1);
    checkOutput("zeroBusy", {63'd0, busy_o}, 64'd0);
    @(negedge clk_i);
    checkOutput("zeroHold", {61'd0, done_o, cfg_err_o, cmd_valid_o}, 64'd6);
    start_i = 1'b0;
    @(negedge clk_i);
    checkOutput("zeroIdle", {62'd0, done_o, busy_o}, 64'd0);
  endtask

  task automatic applyMidReset();
    M_i = 16'd8;
    K_i = 16'd8;
    N_i = 16'd8;
    start_i = 1'b1;
    cmd_ready_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rstPreValid", {63'd0, cmd_valid_o}, 64'd1);
    #2 rst_i = 1'b1;
    #1 checkOutput("rstAsync", 64'(allOut), 64'd0);
    start_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rstReleased", 64'(allOut), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    checkOutput("resetOut", 64'(allOut), 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("idleOut", 64'(allOut), 64'd0);

    applyStimulus(8, 8, 8, 100, 0);
    applyStimulus(5, 6, 4, 100, 0);
    applyStimulus(8, 8, 8, 30, 0);
    applyZero(8, 0, 8);
    applyStimulus(8, 8, 8, 100, 0);
    applyZero(0, 3, 3);
    for (int i = 0; i < 4; i++)
      applyStimulus(int'($urandom_range(1, 13)), int'($urandom_range(1, 13)),
                    int'($urandom_range(1, 13)), int'($urandom_range(30, 100)), 0);
    applyMidReset();
    applyStimulus(4, 4, 4, 100, 0);
    applyStimulus(8, 8, 8, 70, 1);
    applyStimulus(7, 9, 10, 50, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule
